multi_tap_track: RTL

Parametrised successor to the single-tap code wipe-off/accumulate path in the subchannel. Takes carrier-wiped I/Q baseband samples plus the upsampled C/A bit and correlates against NUM_TAPS code replicas spaced TAP_SPACING samples apart (early/prompt/late and wider), in saturating accumulators. Each integration period is dumped into holding registers with a valid/ready handshake, so the next period starts without a gap. It sits between the carrier mixers and the channel tracking loop.

---
 rtl/multi_tap_track_pkg.sv | 24 ++
 rtl/tap_accumulator.sv | 84 ++++++++
 rtl/multi_tap_track.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/multi_tap_track_pkg.sv
// multi_tap_track_pkg: default widths and saturation-limit helpers shared by the
// multi-tap code correlator and its per-tap accumulators.
`default_nettype none

package multi_tap_track_pkg;

  localparam int DEF_SIG_WIDTH   = 4;
  localparam int DEF_ACC_WIDTH   = 16;
  localparam int DEF_NUM_TAPS    = 3;
  localparam int DEF_TAP_SPACING = 2;
  localparam int DEF_CNT_WIDTH   = 16;

  // Largest / smallest value representable in a w-bit two's complement word.
  function automatic longint acc_max(input int unsigned w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic longint acc_min(input int unsigned w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

`default_nettype wire

// File: rtl/tap_accumulator.sv
// tap_accumulator: one I/Q saturating accumulator pair; exposes the clamped
// running sum including the current addend so the epoch sample reaches the dump.
`default_nettype none

module tap_accumulator
  import multi_tap_track_pkg::*;
#(
  parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        flush_i,
  input  logic                        en_i,
  input  logic                        restart_i,
  input  logic signed [ACC_WIDTH-1:0] add_i_i,
  input  logic signed [ACC_WIDTH-1:0] add_q_i,
  output logic signed [ACC_WIDTH-1:0] sum_i_o,
  output logic signed [ACC_WIDTH-1:0] sum_q_o,
  output logic                        sat_o
);

  localparam logic signed [ACC_WIDTH:0] C_MAX = (ACC_WIDTH + 1)'(acc_max(ACC_WIDTH));
  localparam logic signed [ACC_WIDTH:0] C_MIN = (ACC_WIDTH + 1)'(acc_min(ACC_WIDTH));

  logic signed [ACC_WIDTH-1:0] acc_i_q, acc_i_d;
  logic signed [ACC_WIDTH-1:0] acc_q_q, acc_q_d;
  logic signed [ACC_WIDTH:0]   raw_i, raw_q;
  logic                        sat_i, sat_q;

  // One guard bit is enough: two in-range operands cannot overflow ACC_WIDTH+1.
  assign raw_i = {acc_i_q[ACC_WIDTH-1], acc_i_q} + {add_i_i[ACC_WIDTH-1], add_i_i};
  assign raw_q = {acc_q_q[ACC_WIDTH-1], acc_q_q} + {add_q_i[ACC_WIDTH-1], add_q_i};

  always_comb begin
    sum_i_o = raw_i[ACC_WIDTH-1:0];
    sat_i   = 1'b0;
    if (raw_i > C_MAX) begin
      sum_i_o = C_MAX[ACC_WIDTH-1:0];
      sat_i   = 1'b1;
    end else if (raw_i < C_MIN) begin
      sum_i_o = C_MIN[ACC_WIDTH-1:0];
      sat_i   = 1'b1;
    end
  end

  always_comb begin
    sum_q_o = raw_q[ACC_WIDTH-1:0];
    sat_q   = 1'b0;
    if (raw_q > C_MAX) begin
      sum_q_o = C_MAX[ACC_WIDTH-1:0];
      sat_q   = 1'b1;
    end else if (raw_q < C_MIN) begin
      sum_q_o = C_MIN[ACC_WIDTH-1:0];
      sat_q   = 1'b1;
    end
  end

  assign sat_o = en_i & (sat_i | sat_q);

  always_comb begin
    acc_i_d = acc_i_q;
    acc_q_d = acc_q_q;
    if (flush_i) begin
      acc_i_d = '0;
      acc_q_d = '0;
    end else if (en_i) begin
      acc_i_d = restart_i ? '0 : sum_i_o;
      acc_q_d = restart_i ? '0 : sum_q_o;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_i_q <= '0;
      acc_q_q <= '0;
    end else begin
      acc_i_q <= acc_i_d;
      acc_q_q <= acc_q_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/multi_tap_track.sv
// multi_tap_track: NUM_TAPS-tap code wipe-off and saturating integrate-and-dump
// with a two-stage pipeline and a valid/ready dump interface.
`default_nettype none

module multi_tap_track
  import multi_tap_track_pkg::*;
#(
  parameter int SIG_WIDTH   = DEF_SIG_WIDTH,
  parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
  parameter int NUM_TAPS    = DEF_NUM_TAPS,
  parameter int TAP_SPACING = DEF_TAP_SPACING,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
  input  logic                          clk,
  input  logic                          global_reset,
  input  logic                          clear,
  input  logic                          sample_valid,
  input  logic signed [SIG_WIDTH-1:0]   sig_i,
  input  logic signed [SIG_WIDTH-1:0]   sig_q,
  input  logic                          ca_bit,
  input  logic                          epoch,
  output logic                          dump_valid,
  input  logic                          dump_ready,
  output logic [NUM_TAPS*ACC_WIDTH-1:0] dump_i,
  output logic [NUM_TAPS*ACC_WIDTH-1:0] dump_q,
  output logic [CNT_WIDTH-1:0]          dump_count,
  output logic                          dump_saturated,
  output logic                          dump_overrun
);

  localparam int DL_LEN = (NUM_TAPS - 1) * TAP_SPACING;

  logic [NUM_TAPS-1:0] tap_bit;

  assign tap_bit[0] = ca_bit;

  generate
    if (DL_LEN > 0) begin : g_dline
      logic [DL_LEN-1:0] dline_q, dline_d;

      // Bit 0 holds the previous valid sample's code bit, bit d-1 the one d samples back.
      always_comb begin
        dline_d = dline_q;
        if (sample_valid) dline_d = (dline_q << 1) | DL_LEN'(ca_bit);
      end

      always_ff @(posedge clk or posedge global_reset) begin
        if (global_reset) dline_q <= '0;
        else              dline_q <= dline_d;
      end

      for (genvar k = 1; k < NUM_TAPS; k++) begin : g_tapsel
        assign tap_bit[k] = dline_q[k*TAP_SPACING-1];
      end
    end
  endgenerate

  // Stage 1: wiped samples per tap
  logic                        s1_valid_q, s1_valid_d;
  logic                        s1_epoch_q, s1_epoch_d;
  logic signed [ACC_WIDTH-1:0] s1_wi_q [NUM_TAPS];
  logic signed [ACC_WIDTH-1:0] s1_wq_q [NUM_TAPS];
  logic signed [ACC_WIDTH-1:0] s1_wi_d [NUM_TAPS];
  logic signed [ACC_WIDTH-1:0] s1_wq_d [NUM_TAPS];
  logic signed [ACC_WIDTH-1:0] sig_i_ext, sig_q_ext;

  assign sig_i_ext = ACC_WIDTH'(sig_i);
  assign sig_q_ext = ACC_WIDTH'(sig_q);

  always_comb begin
    s1_valid_d = sample_valid & ~clear;
    s1_epoch_d = sample_valid & epoch & ~clear;
    for (int k = 0; k < NUM_TAPS; k++) begin
      s1_wi_d[k] = tap_bit[k] ? sig_i_ext : -sig_i_ext;
      s1_wq_d[k] = tap_bit[k] ? sig_q_ext : -sig_q_ext;
    end
  end

  // Stage 2: accumulate, count, dump
  logic                        acc_en;
  logic                        load;
  logic signed [ACC_WIDTH-1:0] sum_i [NUM_TAPS];
  logic signed [ACC_WIDTH-1:0] sum_q [NUM_TAPS];
  logic [NUM_TAPS-1:0]         tap_sat;
  logic                        sat_any;

  assign acc_en  = s1_valid_q & ~clear;
  assign load    = acc_en & s1_epoch_q;
  assign sat_any = |tap_sat;

  generate
    for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
      tap_accumulator #(
        .ACC_WIDTH(ACC_WIDTH)
      ) u_tap (
        .clk_i     (clk),
        .rst_i     (global_reset),
        .flush_i   (clear),
        .en_i      (acc_en),
        .restart_i (s1_epoch_q),
        .add_i_i   (s1_wi_q[k]),
        .add_q_i   (s1_wq_q[k]),
        .sum_i_o   (sum_i[k]),
        .sum_q_o   (sum_q[k]),
        .sat_o     (tap_sat[k])
      );
    end
  endgenerate

  logic [CNT_WIDTH-1:0]          cnt_q, cnt_d, cnt_inc;
  logic                          flag_q, flag_d;
  logic [NUM_TAPS*ACC_WIDTH-1:0] dump_i_q, dump_i_d;
  logic [NUM_TAPS*ACC_WIDTH-1:0] dump_q_q, dump_q_d;
  logic [CNT_WIDTH-1:0]          dump_cnt_q, dump_cnt_d;
  logic                          dump_sat_q, dump_sat_d;
  logic                          dump_valid_q, dump_valid_d;
  logic                          overrun_q, overrun_d;

  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);

  always_comb begin
    cnt_d        = cnt_q;
    flag_d       = flag_q;
    dump_i_d     = dump_i_q;
    dump_q_d     = dump_q_q;
    dump_cnt_d   = dump_cnt_q;
    dump_sat_d   = dump_sat_q;
    dump_valid_d = dump_valid_q;
    overrun_d    = 1'b0;

    if (clear) begin
      cnt_d  = '0;
      flag_d = 1'b0;
    end else if (acc_en) begin
      cnt_d  = s1_epoch_q ? '0 : cnt_inc;
      flag_d = s1_epoch_q ? 1'b0 : (flag_q | sat_any);
    end

    if (load) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        dump_i_d[k*ACC_WIDTH +: ACC_WIDTH] = sum_i[k];
        dump_q_d[k*ACC_WIDTH +: ACC_WIDTH] = sum_q[k];
      end
      dump_cnt_d   = cnt_inc;
      dump_sat_d   = flag_q | sat_any;
      dump_valid_d = 1'b1;
      // A load in the same cycle as a transfer replaces a dump that was consumed.
      overrun_d    = dump_valid_q & ~dump_ready;
    end else if (dump_valid_q && dump_ready) begin
      dump_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge global_reset) begin
    if (global_reset) begin
      s1_valid_q   <= 1'b0;
      s1_epoch_q   <= 1'b0;
      for (int k = 0; k < NUM_TAPS; k++) begin
        s1_wi_q[k] <= '0;
        s1_wq_q[k] <= '0;
      end
      cnt_q        <= '0;
      flag_q       <= 1'b0;
      dump_i_q     <= '0;
      dump_q_q     <= '0;
      dump_cnt_q   <= '0;
      dump_sat_q   <= 1'b0;
      dump_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_epoch_q   <= s1_epoch_d;
      for (int k = 0; k < NUM_TAPS; k++) begin
        s1_wi_q[k] <= s1_wi_d[k];
        s1_wq_q[k] <= s1_wq_d[k];
      end
      cnt_q        <= cnt_d;
      flag_q       <= flag_d;
      dump_i_q     <= dump_i_d;
      dump_q_q     <= dump_q_d;
      dump_cnt_q   <= dump_cnt_d;
      dump_sat_q   <= dump_sat_d;
      dump_valid_q <= dump_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign dump_valid     = dump_valid_q;
  assign dump_i         = dump_i_q;
  assign dump_q         = dump_q_q;
  assign dump_count     = dump_cnt_q;
  assign dump_saturated = dump_sat_q;
  assign dump_overrun   = overrun_q;

endmodule

`default_nettype wire
